// File: rtl/aes32_shift_rows_stream.sv
// aes32_shift_rows_stream: column-serial ShiftRows/InvShiftRows over two NB-column ping-pong banks.
// Latency: column 0 of a block is on out_data the cycle after its column NB-1 is accepted; 1 col/cycle sustained.
// Backpressure: in_ready falls once both banks are FULL; no combinational path from out_ready or in_* to outputs.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_data/in_inv column input, in_inv taken with column 0;
//        out_valid/out_ready/out_data column output, out_first/out_last mark columns 0 and NB-1 of a block.
// Byte mapping on both sides: [31:24] row 0, [23:16] row 1, [15:8] row 2, [7:0] row 3.
module aes32_shift_rows_stream #(
   parameter int NB = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_inv,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_first,
   output logic        out_last
);

   localparam int            CW   = $clog2(NB);
   localparam int            SW   = CW + 1;
   localparam logic [CW-1:0] LAST = CW'(NB - 1);

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("aes32_shift_rows_stream: NB must be 4, 6 or 8");
   end

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_st_t;

   bank_st_t                  st_q [2];
   bank_st_t                  st_d [2];
   logic [1:0][NB-1:0][31:0]  mem_q, mem_d;
   logic [1:0]                inv_q, inv_d;
   logic                      wsel_q, wsel_d;
   logic                      rsel_q, rsel_d;
   logic [CW-1:0]             wcnt_q, wcnt_d;
   logic [CW-1:0]             rcnt_q, rcnt_d;
   logic                      in_fire;
   logic                      out_fire;

   // Handshake outputs depend on registered bank state only.
   assign in_ready  = (st_q[wsel_q] != BANK_FULL);
   assign out_valid = (st_q[rsel_q] == BANK_FULL);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_first = out_valid & (rcnt_q == '0);
   assign out_last  = out_valid & (rcnt_q == LAST);

   // Row shift offsets: Rijndael with 8 columns shifts rows 2 and 3 one further.
   function automatic logic [SW-1:0] row_off(input int r);
      if (NB == 8 && r >= 2) begin
         return SW'(r + 1);
      end
      return SW'(r);
   endfunction

   // Each output row byte is picked from a rotated column of the read bank.
   // Offsets are below NB, so a single conditional subtract implements mod NB.
   always_comb begin : p_out_mux
      logic [SW-1:0] src;
      out_data = '0;
      src      = '0;
      for (int r = 0; r < 4; r++) begin
         if (inv_q[rsel_q]) begin
            src = {1'b0, rcnt_q} + SW'(NB) - row_off(r);
         end else begin
            src = {1'b0, rcnt_q} + row_off(r);
         end
         if (src >= SW'(NB)) begin
            src = src - SW'(NB);
         end
         out_data[31-8*r -: 8] = mem_q[rsel_q][src[CW-1:0]][31-8*r -: 8];
      end
   end

   // Fill and drain touch different banks whenever both fire (the write bank is
   // never FULL, the read bank always is), so both updates can apply together.
   always_comb begin : p_next
      st_d   = st_q;
      mem_d  = mem_q;
      inv_d  = inv_q;
      wsel_d = wsel_q;
      rsel_d = rsel_q;
      wcnt_d = wcnt_q;
      rcnt_d = rcnt_q;

      if (in_fire) begin
         mem_d[wsel_q][wcnt_q] = in_data;
         if (wcnt_q == '0) begin
            inv_d[wsel_q] = in_inv;
            st_d[wsel_q]  = BANK_FILLING;
         end
         if (wcnt_q == LAST) begin
            st_d[wsel_q] = BANK_FULL;
            wcnt_d       = '0;
            wsel_d       = ~wsel_q;
         end else begin
            wcnt_d = wcnt_q + CW'(1);
         end
      end

      if (out_fire) begin
         if (rcnt_q == LAST) begin
            st_d[rsel_q] = BANK_EMPTY;
            rcnt_d       = '0;
            rsel_d       = ~rsel_q;
         end else begin
            rcnt_d = rcnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : p_regs
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            st_q[b] <= BANK_EMPTY;
         end
         mem_q  <= '0;
         inv_q  <= '0;
         wsel_q <= 1'b0;
         rsel_q <= 1'b0;
         wcnt_q <= '0;
         rcnt_q <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            st_q[b] <= st_d[b];
         end
         mem_q  <= mem_d;
         inv_q  <= inv_d;
         wsel_q <= wsel_d;
         rsel_q <= rsel_d;
         wcnt_q <= wcnt_d;
         rcnt_q <= rcnt_d;
      end
   end

endmodule

// File: tb/tb_aes32_shift_rows_stream.sv
// tb_aes32_shift_rows_stream: scoreboard bench for three instances (NB = 4, 6, 8) sharing clk and rst_n.
// Latency: not applicable; stimulus is driven #1 after rising edges, monitors sample on falling edges.
// Backpressure: out_ready is driven per instance, held, pulsed or randomised by each scenario.
module tb_aes32_shift_rows_stream;

   typedef struct packed {
      logic [31:0] d;
      logic        f;
      logic        l;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid  [3];
   logic        in_ready  [3];
   logic [31:0] in_data   [3];
   logic        in_inv    [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [31:0] out_data  [3];
   logic        out_first [3];
   logic        out_last  [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int GNB = (g == 0) ? 4 : ((g == 1) ? 6 : 8);
      aes32_shift_rows_stream #(.NB(GNB)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .in_inv    (in_inv[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g]),
         .out_first (out_first[g]),
         .out_last  (out_last[g])
      );
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        exp_q [3][$];
   logic [31:0] lit_q [3][$];
   logic [31:0] part  [3][8];
   int          pcnt  [3];
   logic        pinv  [3];
   logic        stall_prev [3];
   logic [31:0] stall_dat  [3];
   logic [31:0] mon_blk [8];
   bit          rnd_done;

   function automatic int nb_of(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 6 : 8);
   endfunction

   // Reference: out column j, row r = in column (j +/- C_r) mod nb, row r.
   function automatic logic [31:0] ref_col(input int nb, input logic [31:0] blk [8],
                                           input logic inv, input int j);
      logic [31:0] res;
      int          off;
      int          src;
      res = '0;
      for (int r = 0; r < 4; r++) begin
         off = (nb == 8 && r >= 2) ? r + 1 : r;
         src = inv ? (j - off + nb) % nb : (j + off) % nb;
         res[31-8*r -: 8] = blk[src][31-8*r -: 8];
      end
      return res;
   endfunction

   task automatic check(input bit ok, input string name, input logic [39:0] act, input logic [39:0] req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: input side builds blocks and pushes expected columns; output side pops and compares.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            pcnt[k]       = 0;
            stall_prev[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (stall_prev[k]) begin
               check(out_valid[k] && out_data[k] == stall_dat[k], "stall_hold",
                     {7'd0, out_valid[k], out_data[k]}, {8'd1, stall_dat[k]});
            end
            if (out_valid[k] && out_ready[k]) begin
               if (exp_q[k].size() == 0) begin
                  check(1'b0, "unexpected_out", {8'd0, out_data[k]}, 40'd0);
               end else begin
                  exp_t e;
                  e = exp_q[k].pop_front();
                  check(out_data[k] == e.d && out_first[k] == e.f && out_last[k] == e.l, "out_col",
                        {2'd0, out_first[k], out_last[k], 4'd0, out_data[k]},
                        {2'd0, e.f, e.l, 4'd0, e.d});
               end
            end
            stall_prev[k] = out_valid[k] && !out_ready[k];
            stall_dat[k]  = out_data[k];
            if (in_valid[k] && in_ready[k]) begin
               if (pcnt[k] == 0) pinv[k] = in_inv[k];
               part[k][pcnt[k]] = in_data[k];
               pcnt[k]++;
               if (pcnt[k] == nb_of(k)) begin
                  bit use_lit;
                  use_lit = (lit_q[k].size() >= nb_of(k));
                  for (int c = 0; c < 8; c++) mon_blk[c] = part[k][c];
                  for (int j = 0; j < nb_of(k); j++) begin
                     exp_t e;
                     e.d = use_lit ? lit_q[k].pop_front() : ref_col(nb_of(k), mon_blk, pinv[k], j);
                     e.f = (j == 0);
                     e.l = (j == nb_of(k) - 1);
                     exp_q[k].push_back(e);
                  end
                  pcnt[k] = 0;
               end
            end
         end
      end
   end

   // Present one column and hold it until accepted; valid stays high on return.
   task automatic drive_col(input int k, input logic [31:0] d, input logic inv);
      int t;
      t = 0;
      in_valid[k] = 1'b1;
      in_data[k]  = d;
      in_inv[k]   = inv;
      @(negedge clk);
      while (!in_ready[k] && t < 300) begin
         t++;
         @(negedge clk);
      end
      if (!in_ready[k]) check(1'b0, "accept_timeout", 40'd0, 40'd1);
      @(posedge clk);
      #1;
   endtask

   // in_inv is scrambled on columns other than 0, which the stage must ignore.
   task automatic send_block(input int k, input logic [31:0] blk [8], input logic inv);
      for (int c = 0; c < nb_of(k); c++) begin
         drive_col(k, blk[c], (c == 0) ? inv : 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic wait_drain(input int k);
      int t;
      t = 0;
      while ((exp_q[k].size() != 0 || out_valid[k]) && t < 400) begin
         @(negedge clk);
         t++;
      end
      check(exp_q[k].size() == 0, "drain_empty", 40'(exp_q[k].size()), 40'd0);
      @(posedge clk);
      #1;
   endtask

   logic [31:0] fips_in  [8];
   logic [31:0] fips_out [8];
   logic [31:0] blk_a    [8];
   logic [31:0] blk_b    [8];

   initial begin
      int acc;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0; in_data[k] = '0; in_inv[k] = 1'b0; out_ready[k] = 1'b0;
      end
      for (int c = 0; c < 8; c++) begin fips_in[c] = '0; fips_out[c] = '0; end
      fips_in[0]  = 32'hd42711ae; fips_in[1]  = 32'he0bf98f1;
      fips_in[2]  = 32'hb8b45de5; fips_in[3]  = 32'h1e415230;
      fips_out[0] = 32'hd4bf5d30; fips_out[1] = 32'he0b452ae;
      fips_out[2] = 32'hb84111f1; fips_out[3] = 32'h1e2798e5;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check(in_ready[k] == 1'b1, "rst_in_ready", 40'(in_ready[k]), 40'd1);
         check(out_valid[k] == 1'b0, "rst_out_valid", 40'(out_valid[k]), 40'd0);
         check(out_data[k] == 32'd0, "rst_out_data", 40'(out_data[k]), 40'd0);
         check({out_first[k], out_last[k]} == 2'b00, "rst_first_last",
               40'({out_first[k], out_last[k]}), 40'd0);
      end
      rst_n = 1'b1;

      // NB=4 FIPS-197 vector, forward then inverse
      out_ready[0] = 1'b1;
      for (int c = 0; c < 4; c++) lit_q[0].push_back(fips_out[c]);
      send_block(0, fips_in, 1'b0);
      in_valid[0] = 1'b0;
      wait_drain(0);
      for (int c = 0; c < 4; c++) lit_q[0].push_back(fips_in[c]);
      send_block(0, fips_out, 1'b1);
      in_valid[0] = 1'b0;
      wait_drain(0);

      // NB=8 byte = {row, column} pattern
      out_ready[2] = 1'b1;
      for (int c = 0; c < 8; c++) blk_a[c] = {4'h0, 4'(c), 4'h1, 4'(c), 4'h2, 4'(c), 4'h3, 4'(c)};
      send_block(2, blk_a, 1'b0);
      in_valid[2] = 1'b0;
      wait_drain(2);
      send_block(2, blk_a, 1'b1);
      in_valid[2] = 1'b0;
      wait_drain(2);

      // NB=4 back-to-back at full rate, second block inverse
      for (int c = 0; c < 8; c++) begin blk_a[c] = $urandom; blk_b[c] = $urandom; end
      fork
         begin
            for (int c = 0; c < 8; c++) begin
               drive_col(0, (c < 4) ? blk_a[c] : blk_b[c-4],
                         (c == 0) ? 1'b0 : ((c == 4) ? 1'b1 : 1'($urandom_range(0, 1))));
            end
            in_valid[0] = 1'b0;
         end
         begin
            for (int n = 0; n < 13; n++) begin
               @(negedge clk);
               check(in_ready[0] == 1'b1, "b2b_in_ready", 40'(n), 40'(n));
               check(out_valid[0] == (n >= 4 && n <= 11), "b2b_out_valid",
                     {8'(n), 31'd0, out_valid[0]}, {8'(n), 31'd0, 1'(n >= 4 && n <= 11)});
            end
         end
      join
      wait_drain(0);

      // NB=6 backpressure
      out_ready[1] = 1'b0;
      acc = 0;
      in_valid[1] = 1'b1; in_data[1] = $urandom; in_inv[1] = 1'($urandom_range(0, 1));
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (!in_ready[1]) break;
         acc++;
         @(posedge clk);
         #1;
         in_data[1] = $urandom; in_inv[1] = 1'($urandom_range(0, 1));
      end
      check(acc == 12, "bp_accepted", 40'(acc), 40'd12);
      @(posedge clk); #1; out_ready[1] = 1'b1;
      @(posedge clk); #1; out_ready[1] = 1'b0;
      @(negedge clk);
      check(in_ready[1] == 1'b0, "bp_after_one", 40'(in_ready[1]), 40'd0);
      @(posedge clk); #1; out_ready[1] = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check(in_ready[1] == 1'b0, "bp_after_five", 40'(in_ready[1]), 40'd0);
      @(posedge clk);
      @(negedge clk);
      check(in_ready[1] == 1'b1, "bp_reopen", 40'(in_ready[1]), 40'd1);
      @(posedge clk);
      #1;
      for (int c = 1; c < 6; c++) drive_col(1, $urandom, 1'($urandom_range(0, 1)));
      in_valid[1] = 1'b0;
      wait_drain(1);

      // Random traffic with random downstream stalls on every instance
      for (int k = 0; k < 3; k++) begin
         rnd_done = 1'b0;
         fork
            begin
               for (int b = 0; b < 5; b++) begin
                  in_valid[k] = 1'b0;
                  repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                  for (int c = 0; c < 8; c++) blk_a[c] = $urandom;
                  send_block(k, blk_a, 1'($urandom_range(0, 1)));
               end
               in_valid[k] = 1'b0;
               rnd_done = 1'b1;
            end
            begin
               while (!rnd_done) begin
                  out_ready[k] = 1'($urandom_range(0, 1));
                  @(posedge clk);
                  #1;
               end
               out_ready[k] = 1'b1;
            end
         join
         wait_drain(k);
      end

      // Reset with block B mid-drain and block A three columns in
      out_ready[0] = 1'b0;
      for (int c = 0; c < 8; c++) begin blk_a[c] = $urandom; blk_b[c] = $urandom; end
      send_block(0, blk_b, 1'b1);
      for (int c = 0; c < 3; c++) drive_col(0, blk_a[c], 1'b0);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin exp_q[k].delete(); lit_q[k].delete(); end
      #1;
      check(out_valid[0] == 1'b0, "mid_rst_out_valid", 40'(out_valid[0]), 40'd0);
      check(in_ready[0] == 1'b1, "mid_rst_in_ready", 40'(in_ready[0]), 40'd1);
      check(out_data[0] == 32'd0, "mid_rst_out_data", 40'(out_data[0]), 40'd0);
      check({out_first[0], out_last[0]} == 2'b00, "mid_rst_first_last",
            40'({out_first[0], out_last[0]}), 40'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) lit_q[0].push_back(fips_out[c]);
      send_block(0, fips_in, 1'b0);
      in_valid[0] = 1'b0;
      wait_drain(0);

      for (int k = 0; k < 3; k++) begin
         check(exp_q[k].size() == 0 && pcnt[k] == 0, "final_idle",
               40'(exp_q[k].size() + pcnt[k]), 40'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
